// File: rtl/div_tick_pkg.sv
// Shared types and constants for the divided-clock tick timer.
package div_tick_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam int CNT_W_DEF   = 8;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/div_edge_det.sv
// Rising-edge detector on the divider level; one-cycle tick per rising edge.
// Optional input synchronizer enabled by SYNC_IN_EN.
module div_edge_det
  import div_tick_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic div_in,
  output logic tick
);
  logic div_s;
  logic div_q;

`ifdef SYNC_IN_EN
  logic [SYNC_STAGES-1:0] sync_q;

  // Flops reset high so a level already high at release does not look like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
  end
  assign div_s = sync_q[SYNC_STAGES-1];
`else
  assign div_s = div_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= 1'b1;
      tick  <= 1'b0;
    end else begin
      div_q <= div_s;
      tick  <= div_s & ~div_q;
    end
  end
endmodule

// File: rtl/div_tick_timer.sv
// Tick-driven down-counter with one-shot/periodic modes, expire pulse and sticky irq.
// Define SYNC_IN_EN to synchronize an asynchronous div_in source.
module div_tick_timer
  import div_tick_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  input  logic             irq_ack,
  output logic             tick,
  output logic             busy,
  output logic             expire,
  output logic             irq,
  output logic [CNT_W-1:0] count
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] period_l, period_l_nxt;
  logic             oneshot_l, oneshot_l_nxt;
  logic             expire_nxt;
  logic             start_ok;

  div_edge_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .div_in (div_in),
    .tick   (tick)
  );

  assign busy = (state == ST_RUN);

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    period_l_nxt  = period_l;
    oneshot_l_nxt = oneshot_l;
    expire_nxt    = 1'b0;
    start_ok      = start && (period != '0);
    case (state)
      ST_IDLE: begin
        if (start_ok && !stop) begin
          state_nxt     = ST_RUN;
          count_nxt     = period;
          period_l_nxt  = period;
          oneshot_l_nxt = oneshot;
        end
      end
      ST_RUN: begin
        // A restart with a zero period behaves like stop.
        if (stop || (start && !start_ok)) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else if (start) begin
          count_nxt     = period;
          period_l_nxt  = period;
          oneshot_l_nxt = oneshot;
        end else if (tick && !hold) begin
          if (count > CNT_W'(1)) begin
            count_nxt = count - CNT_W'(1);
          end else begin
            expire_nxt = 1'b1;
            if (oneshot_l) begin
              state_nxt = ST_IDLE;
              count_nxt = '0;
            end else begin
              count_nxt = period_l;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      period_l  <= '0;
      oneshot_l <= 1'b0;
      expire    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      period_l  <= period_l_nxt;
      oneshot_l <= oneshot_l_nxt;
      expire    <= expire_nxt;
      // A new expiry beats a simultaneous acknowledge.
      irq       <= expire_nxt | (irq & ~irq_ack);
    end
  end
endmodule
